// File: rtl/wb_ram_pkg.sv
// Shared definitions for the Wishbone RAM window: register word offsets,
// CTRL/STATUS bit positions, FSM state encoding and a byte-lane merge helper.
package wb_ram_pkg;

    // Register word offsets from the window base (byte offset = index * 4)
    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_ADDR   = 3'd1;
    localparam logic [2:0] REG_WDATA  = 3'd2;
    localparam logic [2:0] REG_RDATA  = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;
    localparam logic [2:0] REG_ID     = 3'd5;
    localparam logic [2:0] REG_ACNT   = 3'd6;

    localparam int CTRL_ACTIVE  = 0;
    localparam int CTRL_WE      = 1;
    localparam int CTRL_AUTOINC = 2;

    localparam int STAT_ERR  = 0;
    localparam int STAT_WRAP = 1;
    localparam int STAT_BUSY = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RAM_WR  = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_ACK     = 2'd3
    } wb_ram_state_e;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_ram_lat_pipe.sv
// Valid shift register, LAT deep: strobe_o marks the cycle in which read data
// launched by en_i is present on the RAM output.
module wb_ram_lat_pipe
    import wb_ram_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic strobe_o
);

    logic [LAT-1:0] vld_q;

    generate
        if (LAT == 1) begin : g_one
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) vld_q <= '0;
                else       vld_q <= en_i;
            end
        end else begin : g_multi
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) vld_q <= '0;
                else       vld_q <= {vld_q[LAT-2:0], en_i};
            end
        end
    endgenerate

    assign strobe_o = vld_q[LAT-1];

endmodule

// File: rtl/wb_ram_window.sv
// Wishbone-slave register window onto a single-port user RAM.
// Optional build macro WB_RAM_ACCESS_COUNT_EN adds a saturating access counter at offset 0x18.
module wb_ram_window
    import wb_ram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0100,
    parameter int          RAM_AW     = 5,
    parameter int          RAM_DW     = 32,
    parameter int          RAM_RD_LAT = 1,
    parameter logic [31:0] ID_VALUE   = 32'hBAAA_AAAD
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              ram_wb_active,
    output logic              ram_wb_en,
    output logic              ram_wb_we_o,
    output logic [RAM_AW-1:0] ram_wb_addr,
    output logic [RAM_DW-1:0] ram_wb_data_to_ram,
    input  logic [RAM_DW-1:0] ram_wb_data_from_ram
);

`ifdef WB_RAM_ACCESS_COUNT_EN
    localparam logic [29:0] NREGS = 30'd7;
`else
    localparam logic [29:0] NREGS = 30'd6;
`endif

    wb_ram_state_e     state_q, state_d;
    logic [2:0]        ctrl_q, ctrl_d;
    logic [RAM_AW-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       dat_q, dat_d;
    logic              err_q, err_d, wrap_q, wrap_d;
    logic              rd_en_q, rd_en_d;
    logic              abort_q, abort_d;

    logic              err_set, err_clr, wrap_set, wrap_clr, ram_done, cap_stb, busy;
    logic [29:0]       off;
    logic              req;
    logic [2:0]        reg_sel;
    logic [31:0]       rd_val, ctrl_m, addr_m, wdata_m;
    logic              unused_bits;

    assign off     = wbs_adr_i[31:2] - BASE_ADDR[31:2];
    assign req     = wbs_cyc_i && wbs_stb_i && (off < NREGS);
    assign reg_sel = off[2:0];
    assign busy    = (state_q == ST_RAM_WR) || (state_q == ST_RD_WAIT);

    assign ctrl_m  = byte_merge({29'd0, ctrl_q}, wbs_dat_i, wbs_sel_i);
    assign addr_m  = byte_merge(32'(addr_q), wbs_dat_i, wbs_sel_i);
    assign wdata_m = byte_merge(wdata_q, wbs_dat_i, wbs_sel_i);
    assign unused_bits = ^{wbs_adr_i[1:0], ctrl_m[31:3], addr_m[31:RAM_AW]};

`ifdef WB_RAM_ACCESS_COUNT_EN
    logic [15:0] acnt_q;
    logic        acnt_clr;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)                    acnt_q <= '0;
        else if (acnt_clr)               acnt_q <= '0;
        else if (ram_done && !(&acnt_q)) acnt_q <= acnt_q + 16'd1;
    end
`endif

    always_comb begin
        rd_val = '0;
        case (reg_sel)
            REG_CTRL:   rd_val = {29'd0, ctrl_q};
            REG_ADDR:   rd_val = 32'(addr_q);
            REG_WDATA:  rd_val = wdata_q;
            REG_STATUS: rd_val = {29'd0, busy, wrap_q, err_q};
            REG_ID:     rd_val = ID_VALUE;
`ifdef WB_RAM_ACCESS_COUNT_EN
            REG_ACNT:   rd_val = {16'd0, acnt_q};
`endif
            default:    rd_val = '0;
        endcase
    end

    wb_ram_lat_pipe #(.LAT(RAM_RD_LAT)) u_lat_pipe (
        .clk_i    (wb_clk_i),
        .rst_i    (wb_rst_i),
        .en_i     (rd_en_q),
        .strobe_o (cap_stb)
    );

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        dat_d    = dat_q;
        rd_en_d  = 1'b0;
        ram_done = 1'b0;
        err_set  = 1'b0;
        err_clr  = 1'b0;
        wrap_set = 1'b0;
        wrap_clr = 1'b0;
`ifdef WB_RAM_ACCESS_COUNT_EN
        acnt_clr = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (req && !wbs_ack_o) begin
                    state_d = ST_ACK;
                    dat_d   = rd_val;
                    case (reg_sel)
                        REG_CTRL: if (wbs_we_i) ctrl_d = ctrl_m[2:0];
                        REG_ADDR: if (wbs_we_i) addr_d = addr_m[RAM_AW-1:0];
                        REG_WDATA: begin
                            if (wbs_we_i) begin
                                wdata_d = wdata_m;
                                if (!ctrl_q[CTRL_ACTIVE])  err_set = 1'b1;
                                else if (ctrl_q[CTRL_WE])  state_d = ST_RAM_WR;
                            end
                        end
                        REG_RDATA: begin
                            if (!wbs_we_i) begin
                                if (!ctrl_q[CTRL_ACTIVE]) begin
                                    err_set = 1'b1;
                                end else begin
                                    state_d = ST_RD_WAIT;
                                    rd_en_d = 1'b1;
                                end
                            end
                        end
                        REG_STATUS: begin
                            if (wbs_we_i && wbs_sel_i[0]) begin
                                err_clr  = wbs_dat_i[STAT_ERR];
                                wrap_clr = wbs_dat_i[STAT_WRAP];
                            end
                        end
`ifdef WB_RAM_ACCESS_COUNT_EN
                        REG_ACNT: if (wbs_we_i) acnt_clr = 1'b1;
`endif
                        default: ;
                    endcase
                end
            end
            ST_RAM_WR: begin
                ram_done = 1'b1;
                state_d  = ST_IDLE;
            end
            ST_RD_WAIT: begin
                if (cap_stb) begin
                    dat_d    = 32'(ram_wb_data_from_ram);
                    ram_done = 1'b1;
                    state_d  = ST_ACK;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (ram_done && ctrl_q[CTRL_AUTOINC]) begin
            addr_d   = addr_q + 1'b1;
            wrap_set = &addr_q;
        end
        // A set in the same cycle as a write-one-to-clear keeps the bit set
        err_d  = (err_q & ~err_clr) | err_set;
        wrap_d = (wrap_q & ~wrap_clr) | wrap_set;
        // Once the master lets go mid-access, this access must never ack
        abort_d = (state_q != ST_IDLE) && (abort_q || !(wbs_cyc_i && wbs_stb_i));
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            ctrl_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            dat_q   <= '0;
            err_q   <= 1'b0;
            wrap_q  <= 1'b0;
            rd_en_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dat_q   <= dat_d;
            err_q   <= err_d;
            wrap_q  <= wrap_d;
            rd_en_q <= rd_en_d;
            abort_q <= abort_d;
        end
    end

    assign wbs_ack_o = ((state_q == ST_ACK) || (state_q == ST_RAM_WR)) &&
                       wbs_cyc_i && wbs_stb_i && !abort_q;
    assign wbs_dat_o          = dat_q;
    assign ram_wb_active      = ctrl_q[CTRL_ACTIVE];
    assign ram_wb_en          = (state_q == ST_RAM_WR) || rd_en_q;
    assign ram_wb_we_o        = (state_q == ST_RAM_WR);
    assign ram_wb_addr        = addr_q;
    assign ram_wb_data_to_ram = wdata_q[RAM_DW-1:0];

endmodule

// File: doc/wb_ram_window.md
Name: wb_ram_window

Overview:
Parametrised Wishbone-slave window into a single-port user RAM, for the Caravel user area. It maps control, address, data, status and ID registers at a configurable base address. Real RAM read/write cycles happen through a small FSM, with configurable read latency, address auto-increment for streaming, and sticky error/wrap status. It sits between the Wishbone decoder and the RAM port mux.

Parameters:
- BASE_ADDR, 32'h3000_0100: word-aligned base of the register window.
- RAM_AW, 5: RAM address width, 1..16.
- RAM_DW, 32: RAM data width, 1..32.
- RAM_RD_LAT, 1: cycles from ram_en to valid ram_wb_data_from_ram, 1..4.
- ID_VALUE, 32'hBAAA_AAAD: constant returned by the ID register.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset.
- wbs_cyc_i  in  1  bus cycle valid.
- wbs_stb_i  in  1  strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge, one-cycle pulse.
- wbs_dat_o  out  32  read data.
- ram_wb_active  out  1  CTRL.active; requests the RAM mux.
- ram_wb_en  out  1  RAM access strobe, one-cycle pulse.
- ram_wb_we_o  out  1  RAM write enable, valid with ram_wb_en.
- ram_wb_addr  out  RAM_AW  RAM address.
- ram_wb_data_to_ram  out  RAM_DW  RAM write data.
- ram_wb_data_from_ram  in  RAM_DW  RAM read data.

Behaviour:
- Reset: wb_rst_i is asynchronous, active-high; clock is wb_clk_i.
  - All outputs, registers, counters and FSM state go to 0 / IDLE.
  - Reset mid-access aborts the access: no ack, no further ram_wb_en.
- Decode:
  - A request is cyc & stb & adr[31:2] == BASE_ADDR[31:2] + k, with k = 0..5; adr[1:0] is ignored.
  - Any other address is not acknowledged.
- Register map (offset from BASE_ADDR):
  - 0x00 CTRL, RW: bit0 active, bit1 we, bit2 autoinc.
  - 0x04 ADDR, RW: low RAM_AW bits.
  - 0x08 WDATA, RW: holding register.
  - 0x0C RDATA, RO: performs a RAM read.
  - 0x10 STATUS: bit0 err (W1C), bit1 wrap (W1C), bit2 busy (RO).
  - 0x14 ID, RO.
- Byte-lane rules: writes honour wbs_sel_i per byte. Unused high bits read 0. Writes to RO registers are acked and ignored.
- FSM states: IDLE, RAM_WR, RD_WAIT, ACK.
  - IDLE: a new request is accepted only when wbs_ack_o = 0.
  - Plain register access: ack at the cycle after acceptance (1 wait state), then ACK -> IDLE.
  - WDATA write with active=1 and we=1:
    - The holding register updates at acceptance. FSM goes to RAM_WR.
    - RAM_WR: ram_wb_en = 1 and ram_wb_we_o = 1 for one cycle, with data = WDATA[RAM_DW-1:0] and the current ADDR.
    - Ack is asserted in the same cycle.
  - RDATA read with active=1:
    - FSM goes to RD_WAIT. ram_wb_en = 1 with ram_wb_we_o = 0 for one cycle.
    - Data is captured RAM_RD_LAT cycles after ram_en, zero-extended into wbs_dat_o.
    - Ack is asserted the cycle after capture.
    - Total latency from acceptance to ack is RAM_RD_LAT + 2 cycles.
  - WDATA write with we=0: holding register update only, no RAM access.
- Inactive access: WDATA write or RDATA read with active=0 is acked without a RAM access. Reads return 0 and STATUS.err is set.
- Auto-increment:
  - Applies after each completed RAM access when autoinc=1: ADDR <= ADDR+1 mod 2^RAM_AW.
  - Going from all-ones to 0 sets STATUS.wrap.
- Busy: STATUS.busy is 1 in RAM_WR/RD_WAIT. Those states are never observed by a bus read, since requests queue behind ack.
- Abandoned request: if stb/cyc drop before completion, the RAM access still completes (including auto-increment) and the ack is suppressed.
- Simultaneous W1C and set in the same cycle: set wins.

Optional Feature:
- Macro: WB_RAM_ACCESS_COUNT_EN.
- With the macro:
  - Adds a 16-bit RO register at offset 0x18 counting completed RAM accesses (read and write).
  - The counter saturates at 16'hFFFF and is cleared by any write to 0x18 (the write is acked).
  - The decode range becomes k = 0..6.
- Without the macro: 0x18 is not decoded and is never acked.

Decomposition:
- Package wb_ram_pkg holds:
  - register offset localparams;
  - CTRL/STATUS bit indices;
  - FSM state encoding.
- Sub-module wb_ram_lat_pipe: RAM_RD_LAT-deep valid shift register producing the read-capture strobe.
- Decode, registers and FSM stay in wb_ram_window.

Test Plan:
- Write ID offset, then read ID -> ack 1 cycle after acceptance, wbs_dat_o = 32'hBAAA_AAAD; RO write has no effect.
- CTRL=0x7, ADDR=0x1F, WDATA=0xDEADBEEF -> one ram_wb_en+we pulse at addr 0x1F; ADDR then reads 0x00; STATUS.wrap = 1; writing 0x2 to STATUS clears it.
- RAM_RD_LAT=3, CTRL=0x5, ADDR=4, model returns 0x12345678 -> read RDATA acks exactly 5 cycles after acceptance with 0x12345678; ADDR = 5 afterwards.
- CTRL=0, read RDATA -> ack, data 0, no ram_wb_en, STATUS.err = 1; wbs_sel_i=4'b0001 write of 0xFFFFFFFF to WDATA changes only byte 0.
- Assert wb_rst_i during RD_WAIT -> no ack, all outputs 0 immediately, next ID read works normally.
- With WB_RAM_ACCESS_COUNT_EN: 3 RAM writes + 2 reads -> 0x18 reads 5; writing it resets to 0. Without the macro, 0x18 gets no ack within 16 cycles.
